// File: rtl/load_extend_ctrl_if.sv
// Load controller bus bundle: core request, memory port, core response.
// The slave view belongs to the controller; the master view drives it.
interface load_extend_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  modport slave (
    input  req_valid, req_addr, req_funct3,
    input  mem_gnt, mem_rvalid, mem_rdata,
    input  rsp_ready,
    output req_ready, mem_req, mem_addr,
    output rsp_valid, rsp_data, rsp_err, busy
  );

  modport master (
    output req_valid, req_addr, req_funct3,
    output mem_gnt, mem_rvalid, mem_rdata,
    output rsp_ready,
    input  req_ready, mem_req, mem_addr,
    input  rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/load_extend_ctrl.sv
// Load sequencer: word read from data memory, then byte/half extraction
// with sign/zero extension; misalignment and timeouts become error responses.
module load_extend_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic             clk,
  input logic             rst_n,
  load_extend_ctrl_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]    state;
  logic [31:0]   addr_q;
  logic [2:0]    funct3_q;
  logic [CW-1:0] cnt;
  logic [31:0]   data_q;
  logic          err_q;

  logic          bad;
  logic          at_limit;
  logic [31:0]   shifted;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   ext;

  // Moore outputs decoded from state alone
  assign bus.req_ready = (state == S_IDLE);
  assign bus.mem_req   = (state == S_REQ);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.busy      = (state != S_IDLE);
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;

  assign at_limit = (cnt == CNT_MAX);

  // Reject reserved funct3 encodings and misaligned half/word loads
  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      (bus.req_funct3 == 3'b011),
      (bus.req_funct3 == 3'b110),
      (bus.req_funct3 == 3'b111):
        bad = 1'b1;
      (bus.req_funct3[1:0] == 2'b01):
        bad = bus.req_addr[0];
      (bus.req_funct3 == 3'b010):
        bad = (bus.req_addr[1:0] != 2'b00);
      default:
        bad = 1'b0;
    endcase
  end

  // Pick the addressed lane and extend it to 32 bits
  always_comb begin
    shifted = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    byte_v  = shifted[7:0];
    half_v  = addr_q[1] ? bus.mem_rdata[31:16]
                        : bus.mem_rdata[15:0];
    ext     = bus.mem_rdata;
    unique case (funct3_q)
      3'b000:  ext = {{24{byte_v[7]}}, byte_v};
      3'b001:  ext = {{16{half_v[15]}}, half_v};
      3'b100:  ext = {24'h0, byte_v};
      3'b101:  ext = {16'h0, half_v};
      default: ext = bus.mem_rdata;
    endcase
  end

  // Transaction sequencing, timeout counting and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      cnt      <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            addr_q   <= bus.req_addr;
            funct3_q <= bus.req_funct3;
            cnt      <= '0;
            if (bad) begin
              state  <= S_RESP;
              err_q  <= 1'b1;
              data_q <= '0;
            end else begin
              state  <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_gnt) begin
            state <= S_WAIT;
          end else if (at_limit) begin
            state  <= S_RESP;
            err_q  <= 1'b1;
            data_q <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (bus.mem_rvalid) begin
            state  <= S_RESP;
            err_q  <= 1'b0;
            data_q <= ext;
          end else if (at_limit) begin
            state  <= S_RESP;
            err_q  <= 1'b1;
            data_q <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_extend_ctrl.sv
// Bench for load_extend_ctrl: directed loads, timeout/reset corners and
// random loads checked against an arithmetic load model.
module tb_load_extend_ctrl;

  localparam int TO = 3;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  load_extend_ctrl_if bus ();

  load_extend_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Architectural load result: size from funct3, alignment by modulo,
  // extension by two's-complement arithmetic.
  function automatic void model(input logic [31:0] a,
                                input logic [2:0] f,
                                input logic [31:0] rd,
                                output logic [31:0] d,
                                output bit err);
    longint size;
    longint lane;
    longint val;
    d   = 32'h0;
    err = 1'b0;
    if (f == 3'd3 || f == 3'd6 || f == 3'd7) begin
      err = 1'b1;
      return;
    end
    size = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    if ((longint'(a) % size) != 0) begin
      err = 1'b1;
      return;
    end
    lane = longint'(a) % 4;
    val  = (longint'(rd) / (longint'(1) << (8 * lane)))
           % (longint'(1) << (8 * size));
    if (f[2] == 1'b0 && size < 4 &&
        val >= (longint'(1) << (8 * size - 1)))
      val = val - (longint'(1) << (8 * size)) + (longint'(1) << 32);
    d = 32'(val);
  endfunction

  // gd: grant-free REQ cycles; rvd: data-free WAIT cycles; hold: stall cycles
  task automatic run_load(input string nm,
                          input logic [31:0] a,
                          input logic [2:0] f,
                          input logic [31:0] rd,
                          input int gd,
                          input int rvd,
                          input int hold);
    logic [31:0] ed;
    bit          pre;
    int          lat;
    int          reqc;
    logic [31:0] xd;
    logic        xe;
    model(a, f, rd, ed, pre);
    if (pre) begin
      lat = 1; reqc = 0; xd = 0; xe = 1'b1;
    end else if (gd >= TO + 1) begin
      lat = TO + 2; reqc = TO + 1; xd = 0; xe = 1'b1;
    end else if (gd + rvd >= TO + 1) begin
      lat = TO + 3; reqc = gd + 1; xd = 0; xe = 1'b1;
    end else begin
      lat = gd + rvd + 3; reqc = gd + 1; xd = ed; xe = 1'b0;
    end
    chk({nm, ":idle_ready"}, bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = a;
    bus.req_funct3 = f;
    bus.rsp_ready  = 1'b0;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = $urandom;
    bus.req_funct3 = 3'($urandom);
    for (int c = 1; c < lat; c++) begin
      bus.mem_gnt    = !pre && (c == gd + 1);
      bus.mem_rvalid = !pre && (c == gd + 2 + rvd);
      bus.mem_rdata  = (c == gd + 2 + rvd) ? rd : 32'($urandom);
      chk({nm, ":mem_req"}, bus.mem_req, (c <= reqc));
      chk({nm, ":busy"}, bus.busy, 1);
      chk({nm, ":early_rsp"}, bus.rsp_valid, 0);
      chk({nm, ":req_ready_busy"}, bus.req_ready, 0);
      if (c <= reqc)
        chk({nm, ":mem_addr"}, bus.mem_addr, {a[31:2], 2'b00});
      @(posedge clk); #1;
    end
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      bus.rsp_ready = (h == hold);
      chk({nm, ":rsp_valid"}, bus.rsp_valid, 1);
      chk({nm, ":rsp_data"}, bus.rsp_data, xd);
      chk({nm, ":rsp_err"}, bus.rsp_err, xe);
      chk({nm, ":req_ready_rsp"}, bus.req_ready, 0);
      chk({nm, ":mem_req_rsp"}, bus.mem_req, 0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b0;
    chk({nm, ":rsp_drop"}, bus.rsp_valid, 0);
    chk({nm, ":ready_back"}, bus.req_ready, 1);
    chk({nm, ":idle"}, bus.busy, 0);
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_funct3 = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.rsp_ready  = 1'b0;
    #3;
    chk("rst:req_ready", bus.req_ready, 1);
    chk("rst:mem_req", bus.mem_req, 0);
    chk("rst:rsp_valid", bus.rsp_valid, 0);
    chk("rst:busy", bus.busy, 0);
    chk("rst:mem_addr", bus.mem_addr, 0);
    chk("rst:rsp_data", bus.rsp_data, 0);
    chk("rst:rsp_err", bus.rsp_err, 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    run_load("lb", 32'h1003, 3'b000, 32'h80FF_1234, 0, 0, 0);
    chk("lb:const", bus.rsp_data, 32'hFFFF_FF80);
    run_load("lbu", 32'h2002, 3'b100, 32'h9ABC_0000, 0, 0, 0);
    chk("lbu:const", bus.rsp_data, 32'h0000_00BC);
    run_load("lhu", 32'h2002, 3'b101, 32'h9ABC_0000, 1, 0, 0);
    chk("lhu:const", bus.rsp_data, 32'h0000_9ABC);
    run_load("lh", 32'h2002, 3'b001, 32'h9ABC_0000, 0, 1, 0);
    chk("lh:const", bus.rsp_data, 32'hFFFF_9ABC);
    run_load("lw_mis", 32'h3001, 3'b010, 32'h1111_1111, 0, 0, 0);
    chk("lw_mis:err", bus.rsp_err, 1);
    run_load("f011", 32'h3000, 3'b011, 32'h1111_1111, 0, 0, 0);
    run_load("lh_mis", 32'h3003, 3'b001, 32'h1111_1111, 0, 0, 0);
    run_load("gnt_at_limit", 32'h50, 3'b010, 32'hCAFE_F00D, TO, 0, 0);
    run_load("rv_at_limit", 32'h54, 3'b010, 32'h1234_5678, 1, TO - 1, 0);
    run_load("wait_to", 32'h58, 3'b010, 32'h1234_5678, 1, TO, 0);
    run_load("req_to", 32'h5C, 3'b010, 32'h1234_5678, 10, 0, 0);
    chk("req_to:err", bus.rsp_err, 1);

    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stray:busy", bus.busy, 0);
      chk("stray:rsp_valid", bus.rsp_valid, 0);
      chk("stray:rsp_data", bus.rsp_data, 0);
    end
    bus.mem_rvalid = 1'b0;
    run_load("lw_after_to", 32'h60, 3'b010, 32'hA5A5_0F0F, 0, 0, 0);
    chk("lw_after_to:const", bus.rsp_data, 32'hA5A5_0F0F);
    run_load("stall", 32'h71, 3'b100, 32'h0000_C300, 0, 0, 5);
    chk("stall:const", bus.rsp_data, 32'h0000_00C3);

    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h0000_0440;
    bus.req_funct3 = 3'b010;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.mem_gnt    = 1'b1;
    chk("rstw:mem_req", bus.mem_req, 1);
    @(posedge clk); #1;
    bus.mem_gnt    = 1'b0;
    chk("rstw:busy_wait", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw:mem_req0", bus.mem_req, 0);
    chk("rstw:rsp_valid0", bus.rsp_valid, 0);
    chk("rstw:busy0", bus.busy, 0);
    chk("rstw:req_ready1", bus.req_ready, 1);
    chk("rstw:mem_addr0", bus.mem_addr, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstw:no_rsp", bus.rsp_valid, 0);
    run_load("lh_post_rst", 32'h0, 3'b001, 32'h0000_7FFF, 0, 0, 0);
    chk("lh_post_rst:const", bus.rsp_data, 32'h0000_7FFF);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra;
      logic [2:0]  rf;
      ra = $urandom;
      rf = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0 && rf[1:0] != 2'b11)
        ra[1:0] = (rf[1:0] == 2'b10) ? 2'b00 : {ra[1], 1'b0};
      run_load("rand", ra, rf, $urandom,
               $urandom_range(0, 4), $urandom_range(0, 4),
               $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
